// File: rtl/cpu_bus_router.sv
// Single-master, multi-slave CPU bus router: decodes the slave ID from the top address
// bits, forwards one transaction at a time and answers unmapped IDs and timeouts with an error ack.
module cpu_bus_router #(
   parameter int                    NUM_SLAVES     = 12,
   parameter int                    ID_BITS        = 4,
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    TIMEOUT_CYCLES = 1024,
   parameter logic [DATA_WIDTH-1:0] ERROR_DATA     = 32'hDEAD_BEEF
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             m_request,
   input  logic [ADDR_WIDTH-1:0]            m_address,
   input  logic [DATA_WIDTH-1:0]            m_wdata,
   input  logic [DATA_WIDTH/8-1:0]          m_wmask,
   output logic                             m_ack,
   output logic                             m_error,
   output logic [DATA_WIDTH-1:0]            m_rdata,
   output logic [NUM_SLAVES-1:0]            s_request,
   output logic [ADDR_WIDTH-ID_BITS-1:0]    s_address,
   output logic [DATA_WIDTH-1:0]            s_wdata,
   output logic [DATA_WIDTH/8-1:0]          s_wmask,
   input  logic [NUM_SLAVES-1:0]            s_ack,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
   input  logic                             err_clear,
   output logic [7:0]                       err_count,
   output logic [ADDR_WIDTH-1:0]            err_address
);

   localparam int SA_W   = ADDR_WIDTH - ID_BITS;
   localparam int MASK_W = DATA_WIDTH / 8;
   localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   state_t               state, state_next;
   logic [CNT_W-1:0]     cnt, cnt_next;
   logic [ID_BITS-1:0]   lat_id, lat_id_next;
   logic                 m_ack_next, m_error_next;
   logic [DATA_WIDTH-1:0] m_rdata_next;
   logic [NUM_SLAVES-1:0] s_request_next;
   logic [SA_W-1:0]      s_address_next;
   logic [DATA_WIDTH-1:0] s_wdata_next;
   logic [MASK_W-1:0]    s_wmask_next;
   logic [7:0]           err_count_next;
   logic [ADDR_WIDTH-1:0] err_address_next;

   logic [ID_BITS-1:0]   req_id;
   logic                 req_mapped;
   logic [NUM_SLAVES-1:0] req_onehot;
   logic                 sel_ack;
   logic [DATA_WIDTH-1:0] sel_rdata;
   logic                 take_error;

   assign req_id     = m_address[ADDR_WIDTH-1 -: ID_BITS];
   assign req_mapped = (int'(req_id) < NUM_SLAVES);

   // Request one-hot comes from the live address; ack/rdata select from the latched ID.
   always_comb begin
      req_onehot = '0;
      sel_ack    = 1'b0;
      sel_rdata  = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (int'(req_id) == i) begin
            req_onehot[i] = 1'b1;
         end
         if (int'(lat_id) == i) begin
            sel_ack   = s_ack[i];
            sel_rdata = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      state_next       = state;
      cnt_next         = cnt;
      lat_id_next      = lat_id;
      m_ack_next       = 1'b0;
      m_error_next     = 1'b0;
      m_rdata_next     = m_rdata;
      s_request_next   = '0;
      s_address_next   = s_address;
      s_wdata_next     = s_wdata;
      s_wmask_next     = s_wmask;
      err_count_next   = err_count;
      err_address_next = err_address;
      take_error       = 1'b0;

      case (state)
         ST_IDLE: begin
            if (m_request) begin
               s_address_next = m_address[SA_W-1:0];
               s_wdata_next   = m_wdata;
               s_wmask_next   = m_wmask;
               lat_id_next    = req_id;
               cnt_next       = '0;
               if (req_mapped) begin
                  s_request_next = req_onehot;
                  state_next     = ST_WAIT;
               end else begin
                  state_next = ST_ERROR;
               end
            end
         end
         ST_WAIT: begin
            // The ack is tested first so it wins a same-cycle collision with the timeout.
            if (sel_ack) begin
               m_ack_next   = 1'b1;
               m_rdata_next = sel_rdata;
               state_next   = ST_IDLE;
            end else if (cnt == CNT_LAST) begin
               take_error = 1'b1;
               state_next = ST_IDLE;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         ST_ERROR: begin
            take_error = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (take_error) begin
         m_ack_next       = 1'b1;
         m_error_next     = 1'b1;
         m_rdata_next     = ERROR_DATA;
         err_address_next = {lat_id, s_address};
      end

      // A clear coinciding with an error leaves exactly that one error counted.
      if (err_clear) begin
         err_count_next = take_error ? 8'd1 : 8'd0;
      end else if (take_error && (err_count != 8'hFF)) begin
         err_count_next = err_count + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         lat_id      <= '0;
         m_ack       <= 1'b0;
         m_error     <= 1'b0;
         m_rdata     <= '0;
         s_request   <= '0;
         s_address   <= '0;
         s_wdata     <= '0;
         s_wmask     <= '0;
         err_count   <= '0;
         err_address <= '0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         lat_id      <= lat_id_next;
         m_ack       <= m_ack_next;
         m_error     <= m_error_next;
         m_rdata     <= m_rdata_next;
         s_request   <= s_request_next;
         s_address   <= s_address_next;
         s_wdata     <= s_wdata_next;
         s_wmask     <= s_wmask_next;
         err_count   <= err_count_next;
         err_address <= err_address_next;
      end
   end

endmodule

// File: doc/cpu_bus_router.md
# cpu_bus_router

Parametrised single-master, N-slave router for the CPU bus. It decodes the slave ID held in the upper address bits and forwards one transaction at a time to the selected peripheral (RAM, flash, GPIO, I2C, USB, UART, DMA, CFG, SDRAM, FlashRAM, SI, DD, …). It adds unmapped-ID detection, a per-transaction ack timeout and an error status counter. It sits between the CPU core and the peripheral bus.

## Interface
Parameters:
- NUM_SLAVES, 12, number of slave ports; valid IDs are 0..NUM_SLAVES-1.
- ID_BITS, 4, width of the ID field, which occupies address bits [ADDR_WIDTH-1 -: ID_BITS].
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 1024, wait cycles without ack before an error ack; must be ≥2.
- ERROR_DATA, 32'hDEAD_BEEF, value of m_rdata on an error ack.

Ports. There is one clock; reset is synchronous and active-low.
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- m_request  in  1  one-cycle start pulse; request fields are sampled in the same cycle.
- m_address  in  ADDR_WIDTH  transaction address.
- m_wdata  in  DATA_WIDTH  write data.
- m_wmask  in  DATA_WIDTH/8  byte write enables; all-zero means read.
- m_ack  out  1  one-cycle completion pulse.
- m_error  out  1  valid with m_ack; 1 means unmapped ID or timeout.
- m_rdata  out  DATA_WIDTH  read data; valid with m_ack.
- s_request  out  NUM_SLAVES  one-hot, one-cycle request pulse.
- s_address  out  ADDR_WIDTH-ID_BITS  address with the ID stripped; shared by all slaves.
- s_wdata  out  DATA_WIDTH  shared write data.
- s_wmask  out  DATA_WIDTH/8  shared byte write enables.
- s_ack  in  NUM_SLAVES  per-slave ack pulse.
- s_rdata  in  NUM_SLAVES*DATA_WIDTH  flattened read data; slave i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- err_clear  in  1  clears err_count.
- err_count  out  8  saturating error count.
- err_address  out  ADDR_WIDTH  address of the most recent error.

## Operation
- Reset values: all outputs are 0, state is IDLE, the timeout counter is 0 and the latched ID is 0.
- The state machine has three states: IDLE, WAIT and ERROR. Only one transaction is outstanding at a time.
- IDLE with m_request = 1:
  - Latch m_address, m_wdata and m_wmask into s_address, s_wdata and s_wmask.
  - Decode id = m_address ID field.
  - If id ≥ NUM_SLAVES, go to ERROR.
  - Otherwise pulse s_request[id] for exactly one cycle and go to WAIT.
- WAIT:
  - The timeout counter increments every cycle.
  - If s_ack[id] = 1, register s_rdata slice id into m_rdata, pulse m_ack with m_error = 0, and return to IDLE.
  - If the counter reaches TIMEOUT_CYCLES-1 and s_ack[id] = 0, take the error response and return to IDLE.
- ERROR: take the error response and return to IDLE.
- Error response: m_ack = 1, m_error = 1, m_rdata = ERROR_DATA; err_address is loaded with the latched address; err_count increments, saturating at 255.
- s_address, s_wdata and s_wmask are held stable from s_request until the cycle after the ack or timeout.
- m_rdata holds its value between acks.
- Boundary conditions:
  - s_ack from a non-selected slave is ignored in every state.
  - A late s_ack from a timed-out slave is ignored.
  - m_request outside IDLE is ignored and does not queue.
  - If s_ack[id] and the timeout occur in the same cycle, the ack wins and no error is recorded.
  - If err_clear and an error occur in the same cycle, err_count becomes 1. err_clear alone sets err_count to 0. err_address is not affected by err_clear.
  - When NUM_SLAVES = 2^ID_BITS, the ERROR path is unreachable through ID decode.
  - reset_n low mid-transaction aborts it: outputs return to their reset values next edge and no m_ack is produced.

## Timing
- m_request is sampled in cycle 0.
- Mapped access: s_request is high in cycle 1. A slave may ack in cycle 1 or any later cycle k; m_ack is high in cycle k+1.
- Minimum mapped latency is 2 cycles, from m_request to m_ack.
- Unmapped access: m_ack and m_error are high in cycle 2.
- Timeout: the counter is 0 in cycle 1. With no ack, m_ack and m_error are high in cycle TIMEOUT_CYCLES+1.
- A new m_request is accepted from the cycle after m_ack.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Read slave 2:
  - m_address = 32'h2000_0010, m_wmask = 0.
  - Required: s_request = 12'h004 in cycle 1 and s_address = 28'h000_0010.
  - Slave acks in cycle 3 with 32'hCAFE_0001; m_ack = 1 in cycle 4 with m_error = 0 and m_rdata = 32'hCAFE_0001.
- Write slave 8:
  - m_address = 32'h8000_0004, m_wdata = 32'h1234_5678, m_wmask = 4'b0011; the slave acks in the same cycle as s_request.
  - Required: s_wmask = 4'b0011 and s_wdata = 32'h1234_5678 in cycle 1, m_ack in cycle 2.
- Unmapped ID:
  - m_address = 32'hF000_0000.
  - Required: no s_request; m_ack and m_error in cycle 2; m_rdata = 32'hDEAD_BEEF; err_count = 1; err_address = 32'hF000_0000.
- Timeout (TIMEOUT_CYCLES = 16), slave 5 never acks.
  - Required: m_ack and m_error in cycle 17.
  - Then s_ack[5] pulses in cycle 20; required: no m_ack.
- Ack/timeout collision and stray acks (TIMEOUT_CYCLES = 16):
  - The slave acks in exactly cycle 16; required: m_error = 0 in cycle 17 and err_count unchanged.
  - s_ack[3] pulsing while slave 5 is selected is ignored.
- Saturation, clear and reset:
  - 300 unmapped accesses; required: err_count = 255.
  - err_clear together with an error; required: err_count = 1.
  - reset_n low during WAIT; required: outputs are 0 next cycle and no m_ack follows.
